// File: rtl/multi_cycle_ctrl.sv
`timescale 1ns/1ps
// Multi-cycle datapath controller: fetch, decode and per-class execute sequencing
// with memory-ready stalls in IF, MRD and MWR.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       RegWr,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUctr,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_MADR, S_MRD, S_LWB, S_MWR,
        S_REX, S_RWB, S_BEQ, S_JMP, S_IEX, S_IWB
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        IorD       = 1'b0;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        RegWr      = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ExtOp      = 1'b0;
        PCSrc      = 2'b00;
        ALUctr     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IF: begin
                MemRd   = 1'b1;
                ALUSrcB = 2'b01;
                PCWr    = mem_ready;
                IRWr    = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                // Decode uses the live IR field; later states see only op_q.
                op_d    = op;
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
                case (op)
                    OP_RTYPE:        state_d = S_REX;
                    OP_LW, OP_SW:    state_d = S_MADR;
                    OP_BEQ:          state_d = S_BEQ;
                    OP_J:            state_d = S_JMP;
                    OP_ORI, OP_ADDIU: state_d = S_IEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_MADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                state_d = (op_q == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
                if (mem_ready) state_d = S_LWB;
            end
            S_LWB: begin
                RegWr      = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_MWR: begin
                MemWr = 1'b1;
                IorD  = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_IF;
                end
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUctr  = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWr      = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUctr     = 2'b01;
                PCSrc      = 2'b01;
                PCWr       = zero;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_JMP: begin
                PCSrc      = 2'b10;
                PCWr       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (op_q == OP_ORI) begin
                    ExtOp  = 1'b0;
                    ALUctr = 2'b11;
                end else begin
                    ExtOp  = 1'b1;
                    ALUctr = 2'b00;
                end
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWr      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Strobes are gated by reset directly so an aborted access never writes.
        if (!rst_n) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            MemRd      = 1'b0;
            MemWr      = 1'b0;
            RegWr      = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
`timescale 1ns/1ps
// Randomised instruction-level scoreboard for multi_cycle_ctrl: each instruction
// expands into its expected per-cycle control vectors, compared at mid-cycle.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWr, IRWr, IorD, MemRd, MemWr, RegWr, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc, ALUctr;
    logic       ExtOp, instr_done, illegal;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    multi_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWr(PCWr), .IRWr(IRWr), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
        .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .PCSrc(PCSrc), .ALUctr(ALUctr),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        z;
        logic [5:0]  op;
        logic [17:0] exp;
        string       tag;
    } cyc_t;

    cyc_t plan_q[$];

    // Vector order: PCWr IRWr IorD MemRd MemWr RegWr RegDst MemtoReg ALUSrcA ALUSrcB ExtOp PCSrc ALUctr done illegal
    function automatic logic [17:0] mk(input logic pcwr, irwr, iord, memrd, memwr, regwr,
                                       regdst, m2r, srca, input logic [1:0] srcb,
                                       input logic ext, input logic [1:0] pcsrc, aluctr,
                                       input logic done, ill);
        return {pcwr, irwr, iord, memrd, memwr, regwr, regdst, m2r, srca,
                srcb, ext, pcsrc, aluctr, done, ill};
    endfunction

    function automatic logic [17:0] observed();
        return {PCWr, IRWr, IorD, MemRd, MemWr, RegWr, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, ExtOp, PCSrc, ALUctr, instr_done, illegal};
    endfunction

    function automatic logic [5:0] rop();
        logic [5:0] r;
        r = 6'($urandom);
        return r;
    endfunction

    function automatic logic rbit();
        logic b;
        b = 1'($urandom);
        return b;
    endfunction

    function automatic void push(input logic mr, z, input logic [5:0] o,
                                 input logic [17:0] e, input string t);
        cyc_t c;
        c.mr = mr; c.z = z; c.op = o; c.exp = e; c.tag = t;
        plan_q.push_back(c);
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI, OP_ADDIU};
    endfunction

    // Expand one instruction into expected cycles; op is only meaningful in decode.
    function automatic void add_instr(input logic [5:0] opc, input int ifw, input int mw,
                                      input logic z);
        string n;
        n = $sformatf("op%06b", opc);
        for (int i = 0; i < ifw; i++)
            push(1'b0, rbit(), rop(), mk(0,0,0,1,0,0,0,0,0,2'b01,0,2'b00,2'b00,0,0), {n, "_fetchwait"});
        push(1'b1, rbit(), rop(), mk(1,1,0,1,0,0,0,0,0,2'b01,0,2'b00,2'b00,0,0), {n, "_fetch"});
        push(rbit(), rbit(), opc,
             mk(0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,2'b00,0,!is_legal(opc)), {n, "_decode"});
        case (opc)
            OP_LW, OP_SW: begin
                push(rbit(), rbit(), rop(), mk(0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,2'b00,0,0), {n, "_addr"});
                if (opc == OP_LW) begin
                    for (int i = 0; i < mw; i++)
                        push(1'b0, rbit(), rop(), mk(0,0,1,1,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0), {n, "_rdwait"});
                    push(1'b1, rbit(), rop(), mk(0,0,1,1,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0), {n, "_rd"});
                    push(rbit(), rbit(), rop(), mk(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,2'b00,1,0), {n, "_wb"});
                end else begin
                    for (int i = 0; i < mw; i++)
                        push(1'b0, rbit(), rop(), mk(0,0,1,0,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,0), {n, "_wrwait"});
                    push(1'b1, rbit(), rop(), mk(0,0,1,0,1,0,0,0,0,2'b00,0,2'b00,2'b00,1,0), {n, "_wr"});
                end
            end
            OP_RTYPE: begin
                push(rbit(), rbit(), rop(), mk(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,2'b10,0,0), {n, "_exec"});
                push(rbit(), rbit(), rop(), mk(0,0,0,0,0,1,1,0,0,2'b00,0,2'b00,2'b00,1,0), {n, "_wb"});
            end
            OP_BEQ:
                push(rbit(), z, rop(), mk(z,0,0,0,0,0,0,0,1,2'b00,0,2'b01,2'b01,1,0), {n, "_branch"});
            OP_J:
                push(rbit(), rbit(), rop(), mk(1,0,0,0,0,0,0,0,0,2'b00,0,2'b10,2'b00,1,0), {n, "_jump"});
            OP_ORI, OP_ADDIU: begin
                if (opc == OP_ORI)
                    push(rbit(), rbit(), rop(), mk(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,2'b11,0,0), {n, "_exec"});
                else
                    push(rbit(), rbit(), rop(), mk(0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,2'b00,0,0), {n, "_exec"});
                push(rbit(), rbit(), rop(), mk(0,0,0,0,0,1,0,0,0,2'b00,0,2'b00,2'b00,1,0), {n, "_wb"});
            end
            default: ;
        endcase
    endfunction

    localparam logic [17:0] RST_VEC  = 18'b0000_0000_0_01_0_00_00_0_0;
    localparam logic [17:0] IFW_VEC  = 18'b0001_0000_0_01_0_00_00_0_0;

    task automatic drive_cycle(input logic mr, z, input logic [5:0] o, output logic [17:0] obs);
        @(negedge clk);
        mem_ready = mr;
        zero      = z;
        op        = o;
        cyc++;
        #1;
        obs = observed();
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            op = rop();
            #1;
            obs = observed();
            checks++;
            if (obs !== RST_VEC) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, RST_VEC);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== IFW_VEC) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, IFW_VEC);
        end
        $display("reset released, controller in fetch");
    endtask

    // Shared by the scenario tasks below: expands plan_q and compares every cycle.
    task automatic test_plan(input string name, input int limit);
        logic [17:0] obs;
        int n;
        n = (limit < 0 || limit > plan_q.size()) ? plan_q.size() : limit;
        for (int i = 0; i < n; i++) begin
            drive_cycle(plan_q[i].mr, plan_q[i].z, plan_q[i].op, obs);
            checks++;
            if (obs !== plan_q[i].exp) begin
                errors++;
                $display("FAIL %s/%s cycle %0d: got %b expected %b",
                         name, plan_q[i].tag, cyc, obs, plan_q[i].exp);
            end
            if (plan_q[i].exp[1] || plan_q[i].exp[0])
                $display("%s: %s retired at cycle %0d", name, plan_q[i].tag, cyc);
        end
        plan_q.delete();
    endtask

    task automatic test_lw();
        add_instr(OP_LW, 0, 0, 1'b0);
        test_plan("lw", -1);
    endtask

    task automatic test_beq();
        add_instr(OP_BEQ, 0, 0, 1'b0);
        add_instr(OP_BEQ, 0, 0, 1'b1);
        test_plan("beq", -1);
    endtask

    task automatic test_sw_wait();
        add_instr(OP_SW, 0, 3, 1'b0);
        test_plan("sw_wait", -1);
    endtask

    task automatic test_imm();
        add_instr(OP_ORI, 1, 0, 1'b0);
        add_instr(OP_ADDIU, 0, 0, 1'b0);
        test_plan("imm", -1);
    endtask

    task automatic test_illegal();
        add_instr(6'b111111, 0, 0, 1'b0);
        add_instr(OP_RTYPE, 0, 0, 1'b0);
        test_plan("illegal", -1);
    endtask

    task automatic test_reset_mid_wait();
        logic [17:0] obs;
        add_instr(OP_LW, 0, 5, 1'b0);
        test_plan("abort_lw", 5);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            mem_ready = 1'b1;
            #1;
            obs = observed();
            checks++;
            if (obs !== RST_VEC) begin
                errors++;
                $display("FAIL abort_in_reset %0d: got %b expected %b", i, obs, RST_VEC);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== IFW_VEC) begin
            errors++;
            $display("FAIL abort_release: got %b expected %b", obs, IFW_VEC);
        end
        $display("lw aborted by reset, refetch started");
        add_instr(OP_J, 0, 0, 1'b0);
        test_plan("after_abort", -1);
    endtask

    task automatic test_back_to_back();
        add_instr(OP_RTYPE, 0, 0, 1'b0);
        add_instr(OP_LW, 0, 0, 1'b0);
        add_instr(OP_SW, 0, 0, 1'b0);
        add_instr(OP_J, 0, 0, 1'b0);
        add_instr(OP_BEQ, 0, 0, 1'b1);
        add_instr(OP_ADDIU, 0, 0, 1'b0);
        test_plan("b2b", -1);
    endtask

    task automatic test_random();
        logic [5:0] legal_ops [7];
        logic [5:0] o;
        legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI, OP_ADDIU};
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do o = rop(); while (is_legal(o));
            end else begin
                o = legal_ops[$urandom_range(0, 6)];
            end
            add_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end
        test_plan("random", -1);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_beq();
        test_sw_wait();
        test_imm();
        test_illegal();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
